ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
- Sits between the ps2 receiver (key_rdy / key_out byte stream) and the enigma core.
- Decodes PS/2 scan-code set 2 with make, break (F0) and extended (E0) prefixes. Suppresses typematic repeats and maps the 26 letter keys to letter indices 0..25.
- Buffers decoded letters in a small FIFO with a valid/ready handshake to the consumer.
- Escape key flushes the FIFO and pulses a clear request to the core.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
REPEAT_EN, 0, 1 = forward typematic repeats of a held key; 0 = suppress them

Ports:
clk  in  1  system clock
rst_l  in  1  synchronous active-low reset
key_rdy  in  1  one-cycle strobe from the ps2 receiver: key_out holds a new byte
key_out  in  8  received scan-code byte, sampled only when key_rdy=1
letter_valid  out  1  FIFO non-empty; letter is valid
letter  out  5  head-of-FIFO letter index, A=0 .. Z=25
letter_ready  in  1  consumer accepts the head entry when letter_valid=1 in the same cycle
esc_pulse  out  1  one-cycle pulse: Escape make code received
overflow  out  1  one-cycle pulse: a letter was dropped because the FIFO was full
fifo_count  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: rst_l sampled on the clk rising edge; active-low.
  - Takes effect at any time, including mid-prefix sequence and with the FIFO non-empty.
  - After reset: state=IDLE, held code cleared, FIFO empty, letter_valid=0, letter=0, esc_pulse=0, overflow=0, fifo_count=0.
- Bytes are processed only on cycles with key_rdy=1; key_out is ignored otherwise.
- Prefix FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: F0->BRK; E0->EXT; any other byte is a make code, handled as below, and the FSM stays in IDLE.
  - BRK: any byte is a break code. If it equals the held code, clear held. ->IDLE. No output.
  - EXT: F0->EXT_BRK; any other byte ->IDLE. Extended make codes are ignored.
  - EXT_BRK: any byte ->IDLE. Ignored.
- Control bytes 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF, 0xE1 in any state:
  - ignored; state->IDLE; held cleared.
- Make-code handling (IDLE only):
  - Letter map (set 2):
    - A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A
    - N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A
  - Letter make with REPEAT_EN=0 and code == held: dropped (typematic repeat).
  - Otherwise: held <= code, and the letter is pushed.
  - 0x76 (Esc): esc_pulse=1 in the next cycle, FIFO flushed (count->0), held <= 0x76.
  - Any other make code: held <= code, no push.
- Latency: key_rdy with a letter make code in cycle N -> entry written at the N edge.
  - If the FIFO was empty: letter_valid=1 and letter is correct in cycle N+1.
- Handshake:
  - Pop occurs when letter_valid && letter_ready.
  - letter and letter_valid are held stable until the pop.
  - letter_ready while empty has no effect.
- Full: a push with count==DEPTH and no pop in the same cycle is dropped; overflow=1 for one cycle in N+1. FIFO contents are unchanged.
- Simultaneous push and pop:
  - Both performed; count unchanged.
  - Legal when full (no overflow).
  - Legal when count==1: the new entry becomes the head in N+1.
- Flush (Esc) in the same cycle as a pop: flush wins; count=0 next cycle.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Entries come out in exact arrival order across the wrap.
- Outputs are registered; no combinational path from key_rdy or key_out to any output.

Test Plan:
- Reset, then key_rdy with 0x1C, letter_ready=0 -> next cycle letter_valid=1, letter=0, fifo_count=1. Assert letter_ready one cycle -> letter_valid=0, fifo_count=0.
- Sequence 1C, 1C, 1C, F0, 1C, 1C with REPEAT_EN=0, letter_ready=1 -> exactly two letters (0, 0) delivered. Same stream with REPEAT_EN=1 -> four letters delivered.
- E0 1C, then E0 F0 1C, then F0 32 -> no letters, no esc_pulse; FSM back in IDLE. Following 0x32 -> letter=1.
- DEPTH=4, letter_ready=0, push A,B,C,D,E (1C 32 21 23 24, each followed by its F0 break) -> count=4, one overflow pulse on E. Drain -> 0,1,2,3 in order.
- Hold the FIFO full; key_rdy=0x1A in the same cycle as a pop -> no overflow, count stays 4, Z(25) last out. Then 8 further push/pop pairs -> order preserved across pointer wrap.
- Two letters buffered, then 0x76 -> esc_pulse for one cycle, fifo_count=0, letter_valid=0. Separately, rst_l=0 for one cycle after an F0 -> next 0x1C is treated as a make and yields letter 0.

Source files
------------

// File: rtl/ps2_key_ctrl_if.sv
// Bus between the PS/2 key controller, its byte source and its letter consumer.
// Handshake: a letter transfers on any cycle where letter_valid && letter_ready; letter/letter_valid hold until then.
interface ps2_key_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          key_rdy;
    logic [7:0]    key_out;
    logic          letter_valid;
    logic [4:0]    letter;
    logic          letter_ready;
    logic          esc_pulse;
    logic          overflow;
    logic [CW-1:0] fifo_count;
    logic [1:0]    dbg_state;

    modport master (
        output key_rdy, key_out, letter_ready,
        input  letter_valid, letter, esc_pulse, overflow, fifo_count, dbg_state
    );

    modport slave (
        input  key_rdy, key_out, letter_ready,
        output letter_valid, letter, esc_pulse, overflow, fifo_count, dbg_state
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 scan-code decoder: prefix FSM, typematic filter, letter FIFO and Escape flush.
module ps2_key_ctrl #(
    parameter int DEPTH     = 4,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic           clk,
    input  logic           rst_l,
    ps2_key_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t        r_state;
    logic [7:0]    r_held;
    logic [4:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_esc;
    logic          r_ovf;

    logic [5:0]    w_map;
    logic          w_ctrl;
    logic          w_idle_make;
    logic          w_push_req;
    logic          w_esc;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_ovf;

    // Returns {hit, letter index} for a set-2 make code.
    function automatic logic [5:0] f_letter(input logic [7:0] code);
        case (code)
            8'h1C: return {1'b1, 5'd0};   8'h32: return {1'b1, 5'd1};
            8'h21: return {1'b1, 5'd2};   8'h23: return {1'b1, 5'd3};
            8'h24: return {1'b1, 5'd4};   8'h2B: return {1'b1, 5'd5};
            8'h34: return {1'b1, 5'd6};   8'h33: return {1'b1, 5'd7};
            8'h43: return {1'b1, 5'd8};   8'h3B: return {1'b1, 5'd9};
            8'h42: return {1'b1, 5'd10};  8'h4B: return {1'b1, 5'd11};
            8'h3A: return {1'b1, 5'd12};  8'h31: return {1'b1, 5'd13};
            8'h44: return {1'b1, 5'd14};  8'h4D: return {1'b1, 5'd15};
            8'h15: return {1'b1, 5'd16};  8'h2D: return {1'b1, 5'd17};
            8'h1B: return {1'b1, 5'd18};  8'h2C: return {1'b1, 5'd19};
            8'h3C: return {1'b1, 5'd20};  8'h2A: return {1'b1, 5'd21};
            8'h1D: return {1'b1, 5'd22};  8'h22: return {1'b1, 5'd23};
            8'h35: return {1'b1, 5'd24};  8'h1A: return {1'b1, 5'd25};
            default: return 6'd0;
        endcase
    endfunction

    always_comb begin
        w_map       = f_letter(bus.key_out);
        w_ctrl      = bus.key_rdy && (bus.key_out inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1});
        w_idle_make = bus.key_rdy && (r_state == S_IDLE) && !w_ctrl
                      && (bus.key_out != 8'hF0) && (bus.key_out != 8'hE0);
        w_push_req  = w_idle_make && w_map[5] && (REPEAT_EN || (bus.key_out != r_held));
        w_esc       = w_idle_make && (bus.key_out == 8'h76);
        w_pop       = (r_count != '0) && bus.letter_ready;
        w_full      = (r_count == CW'(DEPTH));
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        w_push      = w_push_req && (!w_full || w_pop);
        w_ovf       = w_push_req && w_full && !w_pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state <= S_IDLE;
            r_held  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_esc   <= 1'b0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_esc <= w_esc;
            r_ovf <= w_ovf;

            if (bus.key_rdy) begin
                if (w_ctrl) begin
                    r_state <= S_IDLE;
                    r_held  <= '0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (bus.key_out == 8'hF0)      r_state <= S_BRK;
                            else if (bus.key_out == 8'hE0) r_state <= S_EXT;
                            else                           r_held  <= bus.key_out;
                        end
                        S_BRK: begin
                            if (bus.key_out == r_held) r_held <= '0;
                            r_state <= S_IDLE;
                        end
                        S_EXT:   r_state <= (bus.key_out == 8'hF0) ? S_EXT_BRK : S_IDLE;
                        default: r_state <= S_IDLE;
                    endcase
                end
            end

            // Escape flush overrides any pop in the same cycle; it never coincides with a push.
            if (w_esc) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wptr] <= w_map[4:0];
                    r_wptr        <= r_wptr + 1'b1;
                end
                if (w_pop) r_rptr <= r_rptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.letter_valid = (r_count != '0);
    assign bus.letter       = r_mem[r_rptr];
    assign bus.esc_pulse    = r_esc;
    assign bus.overflow     = r_ovf;
    assign bus.fifo_count   = r_count;
    assign bus.dbg_state    = r_state;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: expected letters queued at issue, popped by a monitor on each transfer.
module tb_ps2_key_ctrl;
  logic clk;
  logic rst_l;
  int   n_tests;
  int   n_fail;
  int   esc_cnt;
  int   ovf_cnt;
  logic ready_base;
  logic sel1;
  logic [4:0] exp0_q[$];
  logic [4:0] exp1_q[$];

  ps2_key_ctrl_if #(.DEPTH(4)) bus0 ();
  ps2_key_ctrl_if #(.DEPTH(4)) bus1 ();

  ps2_key_ctrl #(.DEPTH(4), .REPEAT_EN(1'b0)) dut0 (.clk(clk), .rst_l(rst_l), .bus(bus0.slave));
  ps2_key_ctrl #(.DEPTH(4), .REPEAT_EN(1'b1)) dut1 (.clk(clk), .rst_l(rst_l), .bus(bus1.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_l) begin
      if (bus0.esc_pulse) esc_cnt++;
      if (bus0.overflow) ovf_cnt++;
      if (bus0.letter_valid && bus0.letter_ready) begin
        n_tests++;
        if (exp0_q.size() == 0) begin
          n_fail++;
          $display("FAIL dut0_letter: got %0d expected no letter", bus0.letter);
        end else begin
          logic [4:0] e;
          e = exp0_q.pop_front();
          if (bus0.letter !== e) begin
            n_fail++;
            $display("FAIL dut0_letter: got %0d expected %0d", bus0.letter, e);
          end
        end
      end
      if (bus1.letter_valid && bus1.letter_ready) begin
        n_tests++;
        if (exp1_q.size() == 0) begin
          n_fail++;
          $display("FAIL dut1_letter: got %0d expected no letter", bus1.letter);
        end else begin
          logic [4:0] e;
          e = exp1_q.pop_front();
          if (bus1.letter !== e) begin
            n_fail++;
            $display("FAIL dut1_letter: got %0d expected %0d", bus1.letter, e);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    bus0.key_rdy      = 1'b1;
    bus0.key_out      = b;
    bus0.letter_ready = rdy;
    if (sel1) begin
      bus1.key_rdy = 1'b1;
      bus1.key_out = b;
    end
    tick();
    bus0.key_rdy      = 1'b0;
    bus1.key_rdy      = 1'b0;
    bus0.letter_ready = ready_base;
  endtask

  task automatic press(input logic [7:0] code, input logic [4:0] idx);
    exp0_q.push_back(idx);
    send(code, ready_base);
    send(8'hF0, ready_base);
    send(code, ready_base);
  endtask

  task automatic drain(input string name);
    bus0.letter_ready = 1'b1;
    for (int i = 0; i < 64 && bus0.fifo_count != 0; i++) tick();
    bus0.letter_ready = ready_base;
    check(name, bus0.fifo_count, 0);
    check({name, "_q"}, exp0_q.size(), 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; esc_cnt = 0; ovf_cnt = 0;
    ready_base = 1'b0; sel1 = 1'b0;
    rst_l = 1'b0;
    bus0.key_rdy = 1'b0; bus0.key_out = 8'h00; bus0.letter_ready = 1'b0;
    bus1.key_rdy = 1'b0; bus1.key_out = 8'h00; bus1.letter_ready = 1'b1;
    tick(); tick();
    check("rst_valid", bus0.letter_valid, 0);
    check("rst_letter", bus0.letter, 0);
    check("rst_count", bus0.fifo_count, 0);
    check("rst_esc", bus0.esc_pulse, 0);
    check("rst_ovf", bus0.overflow, 0);
    check("rst_state", bus0.dbg_state, 0);
    rst_l = 1'b1;
    tick();

    // single letter latency and pop
    exp0_q.push_back(5'd0);
    send(8'h1C, 1'b0);
    check("lat_valid", bus0.letter_valid, 1);
    check("lat_letter", bus0.letter, 0);
    check("lat_count", bus0.fifo_count, 1);
    bus0.letter_ready = 1'b1;
    tick();
    bus0.letter_ready = 1'b0;
    check("pop_valid", bus0.letter_valid, 0);
    check("pop_count", bus0.fifo_count, 0);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);

    // typematic: REPEAT_EN=0 gives two letters, REPEAT_EN=1 gives four
    ready_base = 1'b1; sel1 = 1'b1;
    bus0.letter_ready = 1'b1;
    repeat (2) exp0_q.push_back(5'd0);
    repeat (4) exp1_q.push_back(5'd0);
    send(8'h1C, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1);
    repeat (4) tick();
    check("rep_off_q", exp0_q.size(), 0);
    check("rep_on_q", exp1_q.size(), 0);
    sel1 = 1'b0;

    // extended and break sequences produce nothing
    send(8'hE0, 1'b1); send(8'h1C, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h1C, 1'b1);
    send(8'hF0, 1'b1); send(8'h32, 1'b1);
    tick(); tick();
    check("ext_state", bus0.dbg_state, 0);
    check("ext_count", bus0.fifo_count, 0);
    check("ext_esc", esc_cnt, 0);
    exp0_q.push_back(5'd1);
    send(8'h32, 1'b1);
    send(8'hF0, 1'b1); send(8'h32, 1'b1);
    tick();
    check("ext_b_q", exp0_q.size(), 0);

    // fill to DEPTH, overflow on the fifth letter, drain in order
    ready_base = 1'b0;
    bus0.letter_ready = 1'b0;
    press(8'h1C, 5'd0); press(8'h32, 5'd1); press(8'h21, 5'd2); press(8'h23, 5'd3);
    check("full_count", bus0.fifo_count, 4);
    send(8'h24, 1'b0);
    check("ovf_pulse", bus0.overflow, 1);
    check("ovf_count", bus0.fifo_count, 4);
    send(8'hF0, 1'b0);
    check("ovf_clear", bus0.overflow, 0);
    send(8'h24, 1'b0);
    check("ovf_cnt", ovf_cnt, 1);
    drain("drain1");

    // push while full with a simultaneous pop, then wrap the pointers
    press(8'h1C, 5'd0); press(8'h32, 5'd1); press(8'h21, 5'd2); press(8'h23, 5'd3);
    exp0_q.push_back(5'd25);
    send(8'h1A, 1'b1);
    check("fullpp_count", bus0.fifo_count, 4);
    check("fullpp_ovf", bus0.overflow, 0);
    begin
      logic [7:0] codes [8];
      codes = '{8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
      for (int i = 0; i < 8; i++) begin
        exp0_q.push_back(5'(i + 2));
        send(codes[i], 1'b1);
        check("wrap_count", bus0.fifo_count, 4);
      end
    end
    check("wrap_ovf_cnt", ovf_cnt, 1);
    drain("drain2");
    send(8'hF0, 1'b0); send(8'h3B, 1'b0);

    // Escape flushes two buffered letters
    send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0); send(8'h32, 1'b0);
    check("esc_pre_count", bus0.fifo_count, 2);
    send(8'h76, 1'b0);
    check("esc_pulse", bus0.esc_pulse, 1);
    check("esc_count", bus0.fifo_count, 0);
    check("esc_valid", bus0.letter_valid, 0);
    tick();
    check("esc_pulse_end", bus0.esc_pulse, 0);
    check("esc_cnt", esc_cnt, 1);
    send(8'hF0, 1'b0); send(8'h76, 1'b0);

    // reset in the middle of a break prefix
    send(8'hF0, 1'b0);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    check("mid_rst_state", bus0.dbg_state, 0);
    exp0_q.push_back(5'd0);
    send(8'h1C, 1'b0);
    check("mid_rst_letter", bus0.letter, 0);
    check("mid_rst_count", bus0.fifo_count, 1);
    drain("drain3");
    check("final_q1", exp1_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
